// File: rtl/shift8_seq_ctrl.sv
// ============================================================================
// Module  : shift8_seq_ctrl
// Brief   : Multi-cycle sequencer that splits a 0..7 shift into passes of at
//           most 3 through an external 8-bit shift stage, accumulating results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift8_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int AMT_W    = 3,
  parameter int STEP_MAX = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d_in,
  input  logic [AMT_W-1:0] shamt,
  output logic [1:0]       sh_op,
  output logic [1:0]       sh_amt,
  output logic [WIDTH-1:0] sh_din,
  input  logic [WIDTH-1:0] sh_dout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] d_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_OP_ILLEGAL = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [AMT_W-1:0] r_rem;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_dout;
  logic             r_err;

  logic [1:0]       w_step;
  logic [AMT_W-1:0] w_rem_nxt;
  logic             w_accept;
  logic             w_illegal;

  // Full passes first, remainder last: step never exceeds rem, so no underflow.
  assign w_step    = (r_rem > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : r_rem[1:0];
  assign w_rem_nxt = r_rem - AMT_W'(w_step);
  assign w_accept  = (r_state == S_IDLE) && start && (op != c_OP_ILLEGAL);
  assign w_illegal = (r_state == S_IDLE) && start && (op == c_OP_ILLEGAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (shamt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (w_rem_nxt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_rem  <= '0;
      r_op   <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_illegal;
      if (w_accept) begin
        r_acc <= d_in;
        r_rem <= shamt;
        r_op  <= op;
        // A zero-length request bypasses SHIFT, so publish the operand now.
        if (shamt == '0) begin
          r_dout <= d_in;
        end
      end else if (r_state == S_SHIFT) begin
        r_acc <= sh_dout;
        r_rem <= w_rem_nxt;
        if (w_rem_nxt == '0) begin
          r_dout <= sh_dout;
        end
      end
    end
  end

  assign sh_op  = r_op;
  assign sh_din = r_acc;
  assign sh_amt = (r_state == S_SHIFT) ? w_step : 2'd0;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign d_out  = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_shift8_seq_ctrl.sv
// ============================================================================
// Module  : tb_shift8_seq_ctrl
// Brief   : Directed self-checking bench for shift8_seq_ctrl with a behavioural
//           shift stage closing the sh_din -> sh_dout loop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift8_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic [1:0] sh_op;
  logic [1:0] sh_amt;
  logic [7:0] sh_din;
  logic [7:0] sh_dout;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] d_out;

  int n_checks = 0;
  int n_errors = 0;

  shift8_seq_ctrl #(.WIDTH(8), .AMT_W(3), .STEP_MAX(3)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .d_in    (d_in),
    .shamt   (shamt),
    .sh_op   (sh_op),
    .sh_amt  (sh_amt),
    .sh_din  (sh_din),
    .sh_dout (sh_dout),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .d_out   (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift stage: LSL / LSR / ASR by 0..3, pass-through for 11.
  always_comb begin
    sh_dout = sh_din;
    case (sh_op)
      2'b00:   sh_dout = sh_din << sh_amt;
      2'b01:   sh_dout = sh_din >> sh_amt;
      2'b10:   sh_dout = 8'($signed(sh_din) >>> sh_amt);
      default: sh_dout = sh_din;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one request and follow it to done; optionally re-pulse start while
  // busy (must be ignored) and in the done cycle (must not be accepted).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] din,
                       input logic [2:0] sa, input logic [7:0] exp_q, input int exp_lat,
                       input bit poke_busy, input bit poke_done);
    int         lat;
    logic [2:0] rem;
    logic [1:0] stp;
    start = 1'b1; op = o; d_in = din; shamt = sa;
    tick();
    start = 1'b0; d_in = 8'h00; shamt = 3'd0; op = 2'b00;
    lat = 1;
    rem = sa;
    while (!done && lat < 10) begin
      stp = (rem > 3'd3) ? 2'd3 : rem[1:0];
      check_val({tag, " busy_shift"}, 32'(busy), 32'd1);
      check_val({tag, " sh_amt"}, 32'(sh_amt), 32'(stp));
      check_val({tag, " sh_op"}, 32'(sh_op), 32'(o));
      rem = rem - 3'(stp);
      if (poke_busy && lat == 1) begin
        start = 1'b1; op = 2'b01; d_in = 8'hFF; shamt = 3'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, " done"}, 32'(done), 32'd1);
    check_val({tag, " d_out"}, 32'(d_out), 32'(exp_q));
    check_val({tag, " busy_done"}, 32'(busy), 32'd1);
    check_val({tag, " err_done"}, 32'(err), 32'd0);
    check_val({tag, " sh_amt_done"}, 32'(sh_amt), 32'd0);
    if (poke_done) begin
      start = 1'b1; op = 2'b00; d_in = 8'h55; shamt = 3'd1;
    end
    tick();
    start = 1'b0;
    check_val({tag, " done_pulse"}, 32'(done), 32'd0);
    check_val({tag, " busy_idle"}, 32'(busy), 32'd0);
    check_val({tag, " d_out_hold"}, 32'(d_out), 32'(exp_q));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; d_in = 8'h00; shamt = 3'd0;
    #12;
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst err", 32'(err), 32'd0);
    check_val("rst d_out", 32'(d_out), 32'd0);
    check_val("rst sh_din", 32'(sh_din), 32'd0);
    reset_n = 1'b1;
    tick();

    do_op("asr5", 2'b10, 8'hB4, 3'd5, 8'hFD, 3, 1'b0, 1'b0);
    do_op("lsl7", 2'b00, 8'h81, 3'd7, 8'h80, 4, 1'b0, 1'b0);
    do_op("lsr0", 2'b01, 8'h80, 3'd0, 8'h80, 1, 1'b0, 1'b0);
    do_op("lsr3", 2'b01, 8'hF0, 3'd3, 8'h1E, 2, 1'b0, 1'b0);
    do_op("lsl6", 2'b00, 8'h03, 3'd6, 8'hC0, 3, 1'b0, 1'b1);
    do_op("busy_poke", 2'b00, 8'h01, 3'd4, 8'h10, 3, 1'b1, 1'b0);
    do_op("asr1", 2'b10, 8'h7E, 3'd1, 8'h3F, 2, 1'b0, 1'b0);

    // Illegal op: one-cycle err, never busy, result untouched.
    start = 1'b1; op = 2'b11; d_in = 8'hAA; shamt = 3'd2;
    tick();
    start = 1'b0;
    check_val("ill err", 32'(err), 32'd1);
    check_val("ill busy", 32'(busy), 32'd0);
    check_val("ill done", 32'(done), 32'd0);
    check_val("ill d_out", 32'(d_out), 32'h3F);
    tick();
    check_val("ill err_pulse", 32'(err), 32'd0);
    check_val("ill busy2", 32'(busy), 32'd0);

    // Reset in the middle of a 7-step shift.
    start = 1'b1; op = 2'b00; d_in = 8'h81; shamt = 3'd7;
    tick();
    start = 1'b0;
    tick();
    check_val("mid busy_pre", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid busy", 32'(busy), 32'd0);
    check_val("mid done", 32'(done), 32'd0);
    check_val("mid d_out", 32'(d_out), 32'd0);
    check_val("mid sh_din", 32'(sh_din), 32'd0);
    check_val("mid sh_amt", 32'(sh_amt), 32'd0);
    check_val("mid sh_op", 32'(sh_op), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("mid no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    tick();
    check_val("post busy", 32'(busy), 32'd0);
    do_op("post_lsr0", 2'b01, 8'h80, 3'd0, 8'h80, 1, 1'b0, 1'b0);
    do_op("post_asr5", 2'b10, 8'hB4, 3'd5, 8'hFD, 3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
